// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, one-word-line, write-through, no-write-allocate data cache
// serving the core's dcache port. Misses and all writes go to a backing memory over a
// valid/ready request channel with a separate response-valid channel.
// Optional: define DCACHE_STATS_EN to add read hit/miss counters (stat_hits, stat_misses).
module dcache_responder #(
  parameter int unsigned LINES  = 64,
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic             idle, hit, rd_hit, rd_miss, wr_acc, fill;

  assign idx      = cpu_addr[IDX_W-1:0];
  assign tag      = cpu_addr[ADDR_W-1:IDX_W];
  // The latched request address doubles as the fill address for the pending miss.
  assign fill_idx = mem_req_addr[IDX_W-1:0];
  assign fill_tag = mem_req_addr[ADDR_W-1:IDX_W];

  assign idle    = (state_q == StIdle);
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  // A non-zero byte enable makes the request a write; cpu_re is then ignored.
  assign wr_acc  = idle && (|cpu_we);
  assign rd_hit  = idle && !(|cpu_we) && cpu_re && hit;
  assign rd_miss = idle && !(|cpu_we) && cpu_re && !hit;
  assign fill    = (state_q == StRdWait) && mem_resp_valid;

  assign stall         = !idle;
  assign mem_req_valid = (state_q == StRdReq) || (state_q == StWrReq);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_acc) begin
          state_d = StWrReq;
        end else if (rd_miss) begin
          state_d = StRdReq;
        end
      end
      StRdReq:  if (mem_req_ready)  state_d = StRdWait;
      StRdWait: if (mem_resp_valid) state_d = StIdle;
      StWrReq:  if (mem_req_ready)  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Capture the outgoing request at acceptance; it stays put until the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_rw   <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_mask <= '0;
    end else if (wr_acc) begin
      mem_req_rw   <= 1'b1;
      mem_req_addr <= cpu_addr;
      mem_req_data <= cpu_din;
      mem_req_mask <= cpu_we;
    end else if (rd_miss) begin
      mem_req_rw   <= 1'b0;
      mem_req_addr <= cpu_addr;
      mem_req_data <= '0;
      mem_req_mask <= 4'hF;
    end
  end

  // Valid bits: cleared by reset, set when a fill lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: byte merge on a write hit, whole-line install on a fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_acc && hit) begin
        for (int i = 0; i < 4; i++) begin
          if (cpu_we[i]) data_q[idx][8*i +: 8] <= cpu_din[8*i +: 8];
        end
      end
      if (fill) begin
        data_q[fill_idx] <= mem_resp_data;
        tag_q[fill_idx]  <= fill_tag;
      end
    end
  end

  // Load data: hit data one cycle after acceptance, or fill data as the miss retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout <= '0;
    end else if (rd_hit) begin
      cpu_dout <= data_q[idx];
    end else if (fill) begin
      cpu_dout <= mem_resp_data;
    end
  end

`ifdef DCACHE_STATS_EN
  // Read hit/miss counters, counted at acceptance; writes are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (rd_hit)  stat_hits   <= stat_hits + 32'd1;
      if (rd_miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized, self-checking bench for dcache_responder. The reference is
// a transaction-level model: a backing-memory map plus a per-line record of which full address
// the cache holds. Each transaction task knows, from the model, the exact cycle-by-cycle
// shape the DUT outputs must take and checks them once per cycle.
module tb_dcache_responder;

  localparam int unsigned LINES  = 16;
  localparam int unsigned ADDR_W = 30;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_re;
  logic [3:0]        cpu_we;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic [3:0]        mem_req_mask;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;
`ifdef DCACHE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
`endif

  dcache_responder #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  logic [31:0]       mem_m [logic [ADDR_W-1:0]];
  logic              mvalid [LINES];
  logic [ADDR_W-1:0] maddr  [LINES];
  logic [31:0]       mdata  [LINES];
  int                n_hits, n_misses;

  // Expected outputs for the current cycle.
  logic              exp_stall, exp_req_valid, exp_dout_chk, exp_rw;
  logic [31:0]       exp_dout, exp_data;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        exp_mask;

  int vectors, miscompares;
  int stall_seen;

  function automatic logic [31:0] mem_read(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    if (mem_m.exists(a)) return mem_m[a];
    t = 32'(a) * 32'h9E37_79B1;
    return t ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int line_of(input logic [ADDR_W-1:0] a);
    return int'(32'(a) % LINES);
  endfunction

  function automatic logic cached(input logic [ADDR_W-1:0] a);
    return mvalid[line_of(a)] && (maddr[line_of(a)] == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    n_hits   = 0;
    n_misses = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectation.
  task automatic compare_cycle();
    check("stall", 32'(stall), 32'(exp_stall));
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req_valid));
    if (exp_req_valid) begin
      check("mem_req_rw", 32'(mem_req_rw), 32'(exp_rw));
      check("mem_req_addr", 32'(mem_req_addr), 32'(exp_addr));
      check("mem_req_mask", 32'(mem_req_mask), 32'(exp_mask));
      if (exp_rw) check("mem_req_data", mem_req_data, exp_data);
    end
    if (exp_dout_chk) check("cpu_dout", cpu_dout, exp_dout);
  endtask

  // Advance one clock, then check what the DUT shows after that edge.
  task automatic step(input logic st, input logic rv, input logic dchk, input logic [31:0] d);
    @(posedge clk);
    #1;
    exp_stall     = st;
    exp_req_valid = rv;
    exp_dout_chk  = dchk;
    exp_dout      = d;
    if (stall) stall_seen++;
    compare_cycle();
  endtask

  // Response-valid pulses the cache must ignore when not waiting for a fill.
  task automatic stray();
    mem_resp_valid = ($urandom_range(0, 3) == 0);
    mem_resp_data  = $urandom;
  endtask

  task automatic do_idle();
    cpu_re        = 1'b0;
    cpu_we        = 4'h0;
    cpu_addr      = ADDR_W'($urandom);
    mem_req_ready = 1'($urandom_range(0, 1));
    stray();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int rdelay, input int rsp);
    logic [31:0] v;
    int          i;
    i          = line_of(a);
    stall_seen = 0;
    cpu_addr   = a;
    cpu_re     = 1'b1;
    cpu_we     = 4'h0;
    cpu_din    = $urandom;
    mem_req_ready = 1'($urandom_range(0, 1));
    stray();
    if (cached(a)) begin
      n_hits++;
      step(1'b0, 1'b0, 1'b1, mdata[i]);
    end else begin
      n_misses++;
      exp_rw   = 1'b0;
      exp_addr = a;
      exp_mask = 4'hF;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < rdelay; k++) begin
        stray();
        mem_req_ready = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h0);
      end
      stray();
      mem_req_ready = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      mem_req_ready = 1'($urandom_range(0, 1));
      for (int k = 1; k < rsp; k++) begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        step(1'b1, 1'b0, 1'b0, 32'h0);
      end
      v              = mem_read(a);
      mem_resp_valid = 1'b1;
      mem_resp_data  = v;
      step(1'b0, 1'b0, 1'b1, v);
      mem_resp_valid = 1'b0;
      mvalid[i] = 1'b1;
      maddr[i]  = a;
      mdata[i]  = v;
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [3:0] we,
                          input logic [31:0] din, input int wdelay);
    int i;
    i          = line_of(a);
    stall_seen = 0;
    cpu_addr   = a;
    cpu_we     = we;
    cpu_din    = din;
    cpu_re     = 1'($urandom_range(0, 1));
    exp_rw     = 1'b1;
    exp_addr   = a;
    exp_data   = din;
    exp_mask   = we;
    mem_req_ready = 1'($urandom_range(0, 1));
    stray();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < wdelay; k++) begin
      stray();
      mem_req_ready = 1'b0;
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    stray();
    mem_req_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_m[a] = merge(mem_read(a), din, we);
    if (cached(a)) mdata[i] = merge(mdata[i], din, we);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(0, 4 * LINES - 1));
    if ($urandom_range(0, 3) == 0) a[ADDR_W-1] = 1'b1;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    cpu_addr      = '0;
    cpu_re        = 1'b0;
    cpu_we        = 4'h0;
    cpu_din       = 32'h0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    exp_rw        = 1'b0;
    exp_addr      = '0;
    exp_data      = 32'h0;
    exp_mask      = 4'h0;
    model_reset();
    mem_m[ADDR_W'(32'h10)] = 32'hDEAD_BEEF;

    // Reset state.
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("reset_req_rw", 32'(mem_req_rw), 32'h0);
    check("reset_req_addr", 32'(mem_req_addr), 32'h0);
    check("reset_req_data", mem_req_data, 32'h0);
    check("reset_req_mask", 32'(mem_req_mask), 32'h0);
`ifdef DCACHE_STATS_EN
    check("reset_stat_hits", stat_hits, 32'h0);
    check("reset_stat_misses", stat_misses, 32'h0);
`endif
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h0);

    // Cold read: one RD_REQ cycle plus three RD_WAIT cycles of stall.
    do_read(ADDR_W'(32'h10), 0, 3);
    check("cold_read_stall_cycles", 32'(stall_seen), 32'd4);
    check("cold_read_data", cpu_dout, 32'hDEAD_BEEF);

    // Repeat read hits with no stall.
    do_read(ADDR_W'(32'h10), 0, 1);
    check("hit_stall_cycles", 32'(stall_seen), 32'd0);
    check("hit_data", cpu_dout, 32'hDEAD_BEEF);

    // Write hit merges low half, then read observes merged word without a miss.
    do_write(ADDR_W'(32'h10), 4'b0011, 32'h0000_1234, 2);
    do_read(ADDR_W'(32'h10), 0, 1);
    check("write_merge_stall_cycles", 32'(stall_seen), 32'd0);
    check("write_merge_data", cpu_dout, 32'hDEAD_1234);

    // Conflict eviction on the same line.
    do_read(ADDR_W'(32'h10 + LINES), 0, 1);
    check("conflict_miss_stall_cycles", 32'(stall_seen), 32'd2);
    do_read(ADDR_W'(32'h10), 0, 1);
    check("evicted_refetch_stall_cycles", 32'(stall_seen), 32'd2);
    check("evicted_refetch_data", cpu_dout, 32'hDEAD_1234);

    // Write miss does not allocate; the following read refetches the written word.
    do_write(ADDR_W'(32'h25), 4'hF, 32'hCAFE_F00D, 0);
    do_read(ADDR_W'(32'h25), 1, 2);
    check("write_miss_refetch_stall_cycles", 32'(stall_seen), 32'd4);
    check("write_miss_refetch_data", cpu_dout, 32'hCAFE_F00D);

    // Reset while a read miss is stuck in RD_REQ with ready low.
    cpu_addr       = ADDR_W'(32'h33);
    cpu_re         = 1'b1;
    cpu_we         = 4'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    exp_rw         = 1'b0;
    exp_addr       = ADDR_W'(32'h33);
    exp_mask       = 4'hF;
    n_misses++;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    reset  = 1'b1;
    cpu_re = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    model_reset();
    check("midreset_req_addr", 32'(mem_req_addr), 32'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    mem_resp_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    do_read(ADDR_W'(32'h33), 0, 1);
    check("post_reset_late_resp_no_fill", 32'(stall_seen), 32'd2);

    // Hit, miss, hit, write.
    do_read(ADDR_W'(32'h33), 0, 1);
    do_read(ADDR_W'(32'h44), 0, 2);
    do_read(ADDR_W'(32'h44), 0, 1);
    do_write(ADDR_W'(32'h44), 4'b1000, 32'hAB00_0000, 1);
`ifdef DCACHE_STATS_EN
    // One miss on 0x33 precedes the sequence.
    check("stat_hits_seq", stat_hits, 32'd2);
    check("stat_misses_seq", stat_misses, 32'd2);
`endif

    // Valid bits were cleared by reset: the old 0x10 line is gone.
    do_read(ADDR_W'(32'h10), 0, 1);
    check("post_reset_valid_cleared", 32'(stall_seen), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        do_idle();
      end else if (op < 7) begin
        do_read(rand_addr(), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      end else begin
        do_write(rand_addr(), 4'($urandom_range(1, 15)), $urandom,
                 int'($urandom_range(0, 3)));
      end
    end
    do_idle();

`ifdef DCACHE_STATS_EN
    check("stat_hits_final", stat_hits, 32'(n_hits));
    check("stat_misses_final", stat_misses, 32'(n_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side memory responder that serves the core's dcache port: word address, read request, 4-bit byte write enable, write data, read data and stall.
- Direct-mapped, one-word-line, write-through, no-write-allocate cache. Tag, valid and data arrays are held in flops.
- Misses and writes are forwarded to a backing memory over a valid/ready request channel with a separate response-valid channel.
- Sits between the pipeline's writeback stage and the memory system, and is the sole source of the core's stall input.

Parameters:
- LINES, 64, number of cache lines; power of two, at least 2. IDX_W = log2(LINES).
- ADDR_W, 30, width of the word address from the core.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cpu_addr  input  ADDR_W  word address. Index = cpu_addr[IDX_W-1:0]; tag = cpu_addr[ADDR_W-1:IDX_W].
- cpu_re  input  1  read request
- cpu_we  input  4  byte write enables; bit i covers din[8i+7:8i]
- cpu_din  input  32  store data
- cpu_dout  output  32  load data
- stall  output  1  core must hold its request and all pipeline state while high
- mem_req_valid  output  1  backing-memory request valid
- mem_req_ready  input  1  backing memory accepts the request
- mem_req_rw  output  1  1 = write, 0 = read
- mem_req_addr  output  ADDR_W  word address
- mem_req_data  output  32  write data
- mem_req_mask  output  4  byte mask; 4'hF for reads
- mem_resp_valid  input  1  read data valid, one cycle per read request
- mem_resp_data  input  32  read data

Behaviour:
- Request acceptance: a request is accepted on a posedge when state is IDLE and (cpu_re or |cpu_we). If |cpu_we, the request is a write and cpu_re is ignored; cpu_dout is don't-care for that request.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE, read hit (valid[idx] and tag match): cpu_dout = data[idx] on the next cycle (1-cycle latency). Stay IDLE; stall stays 0.
  - IDLE, read miss: go to RD_REQ and latch the address.
  - IDLE, write: on a hit, merge the masked bytes into data[idx] at acceptance. On a miss, leave the arrays unchanged. Latch addr/din/mask and go to WR_REQ.
  - RD_REQ: mem_req_valid=1, rw=0, mask=4'hF. On mem_req_ready go to RD_WAIT.
  - RD_WAIT: on mem_resp_valid, write data[idx], tag[idx] and valid[idx]=1, register cpu_dout=mem_resp_data, go to IDLE.
  - WR_REQ: mem_req_valid=1, rw=1. On mem_req_ready go to IDLE.
- stall = (state != IDLE), a registered-state decode. It rises the cycle after a miss or write is accepted. It falls in the same cycle cpu_dout carries the fill data (read) or the cycle after the handshake (write).
- The core holds its inputs stable while stall=1. Inputs presented while stall=1 are not sampled.
- mem_req_* fields stay stable while mem_req_valid=1 and ready=0. mem_req_valid is never withdrawn without a handshake except by reset.
- mem_resp_valid outside RD_WAIT is ignored.
- Reset values: state=IDLE, all valid bits=0, stall=0, mem_req_valid=0, cpu_dout=0, mem_req_rw/addr/data/mask=0.
- Reset mid-miss or mid-write: the FSM returns to IDLE and the pending request is dropped. A response arriving after reset is ignored because state is IDLE.
- Back-to-back hits: one accepted per cycle, no bubbles.
- Read immediately after a write to the same address: the write completes first (stall), so the read observes the merged data on a hit. After a write miss, the read misses and refetches.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs stat_hits [31:0] and stat_misses [31:0].
  - stat_hits increments on each accepted read hit.
  - stat_misses increments on each accepted read miss.
  - Writes are not counted.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Cold read addr=0x10, memory returns 0xDEADBEEF after 3 cycles -> stall high for RD_REQ plus 3 wait cycles; cpu_dout=0xDEADBEEF when stall falls; valid[0x10 mod LINES]=1.
- Repeat read addr=0x10 -> no mem_req; cpu_dout=0xDEADBEEF one cycle later; stall stays 0.
- Write addr=0x10, we=4'b0011, din=0x00001234 (hit) -> mem_req rw=1, mask=0011, data=0x00001234; stall until ready. A following read returns 0xDEAD1234 with no miss.
- Conflict: read addr=0x10 then addr=0x10+LINES -> second read misses and evicts; a third read of 0x10 misses again.
- mem_req_ready held 0 for 5 cycles during RD_REQ -> mem_req fields stable, stall held. Assert reset in cycle 3 -> state IDLE, valid bits cleared; a later mem_resp_valid is ignored and does not fill.
- With DCACHE_STATS_EN: sequence hit, miss, hit, write -> stat_hits=2, stat_misses=1.
